hx711_reader: RTL and testbench

Parametrised HX711 load-cell ADC reader, the successor to the fixed 25-pulse reader in the weighing front end.
- Adds runtime channel/gain select (25/26/27 SCK pulses), a configurable SCK rate and a ready-timeout.
- Adds explicit power-down control, signed sample output with valid strobe, and a power-of-two block averager.
- Feeds the weight-processing logic through `sample`/`avg` plus single-cycle valid pulses.

---
 rtl/hx711_pkg.sv | 32 +++
 rtl/hx711_avg.sv | 65 ++++++
 rtl/hx711_reader.sv | 182 ++++++++++++++++++
 tb/tb_hx711_reader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hx711_pkg.sv
// Shared definitions for the HX711 reader: gain encodings, pulse counts
// per gain, and the frame-sequencer state encoding.
package hx711_pkg;

   // Gain/channel encodings as presented on gain_sel and sample_gain.
   localparam logic [1:0] GAIN_A128 = 2'b00;
   localparam logic [1:0] GAIN_B32  = 2'b01;
   localparam logic [1:0] GAIN_A64  = 2'b10;

   typedef enum logic [2:0] {
      ST_WAIT_RDY = 3'd0,
      ST_SCK_HI   = 3'd1,
      ST_SCK_LO   = 3'd2,
      ST_LATCH    = 3'd3,
      ST_PWRDN    = 3'd4
   } hx711_state_t;

   // The reserved code 2'b11 behaves as channel A, gain 128.
   function automatic logic [1:0] norm_gain(input logic [1:0] gain);
      return (gain == 2'b11) ? GAIN_A128 : gain;
   endfunction

   // Total PD_SCK pulses per frame: 24 data bits plus 1..3 gain-select pulses.
   function automatic logic [4:0] pulses_for(input logic [1:0] gain);
      case (gain)
         GAIN_B32: return 5'd26;
         GAIN_A64: return 5'd27;
         default:  return 5'd25;
      endcase
   endfunction

endpackage

// File: rtl/hx711_avg.sv
// Power-of-two block averager. Sums 2^AVG_LOG2 signed samples, then
// publishes the floor of the mean and pulses o_avg_valid for one cycle.
// i_clr discards a partial block; a sample that completes a block wins.
module hx711_avg #(
   parameter int AVG_LOG2 = 2
) (
   input  logic        clk_50,
   input  logic        rst_n,
   input  logic        i_clr,
   input  logic        i_valid,
   input  logic [23:0] i_sample,
   output logic [23:0] o_avg,
   output logic        o_avg_valid
);

   localparam int ACC_W = 24 + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   logic signed [ACC_W-1:0] r_acc;
   logic        [CNT_W-1:0] r_cnt;
   logic        [23:0]      r_avg;
   logic                    r_avg_valid;

   logic signed [ACC_W-1:0] w_acc_next;
   logic signed [ACC_W-1:0] w_mean;

   // Sign-extend the incoming sample into the wider accumulator.
   assign w_acc_next = r_acc + ACC_W'($signed(i_sample));
   // Arithmetic shift gives the mean rounded toward minus infinity.
   assign w_mean     = w_acc_next >>> AVG_LOG2;

   // Accumulate samples; publish and restart on the last sample of a block.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_avg       <= '0;
         r_avg_valid <= 1'b0;
      end else begin
         r_avg_valid <= 1'b0;
         if (i_valid) begin
            if (r_cnt == CNT_LAST) begin
               r_avg       <= w_mean[23:0];
               r_avg_valid <= 1'b1;
               r_acc       <= '0;
               r_cnt       <= '0;
            end else if (i_clr) begin
               r_acc <= '0;
               r_cnt <= '0;
            end else begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else if (i_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
         end
      end
   end

   assign o_avg       = r_avg;
   assign o_avg_valid = r_avg_valid;

endmodule

// File: rtl/hx711_reader.sv
// HX711 load-cell ADC reader: waits for DOUT low, clocks out 24 data bits
// plus gain-select pulses, publishes the signed sample and feeds the block
// averager. sample_valid / avg_valid are single-cycle strobes with no
// back-pressure: the consumer must take the value in the strobe cycle.
module hx711_reader
   import hx711_pkg::*;
#(
   parameter int SCK_HALF       = 32,
   parameter int TIMEOUT_CYCLES = 5000000,
   parameter int AVG_LOG2       = 2
) (
   input  logic        clk_50,
   input  logic        rst_n,
   input  logic        dout,
   output logic        pd_sck,
   input  logic        enable,
   input  logic [1:0]  gain_sel,
   output logic [23:0] sample,
   output logic [1:0]  sample_gain,
   output logic        sample_valid,
   output logic [23:0] avg,
   output logic        avg_valid,
   output logic        timeout,
   output logic [2:0]  state_dbg
);

   localparam int PH_W = $clog2(SCK_HALF);
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(SCK_HALF - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic               r_dout_m;
   logic               r_dout_s;
   hx711_state_t       r_state;
   logic [PH_W-1:0]    r_phase;
   logic [TO_W-1:0]    r_to_cnt;
   logic [4:0]         r_bit_cnt;
   logic [4:0]         r_target;
   logic [1:0]         r_gain;
   logic [1:0]         r_prev_gain;
   logic [23:0]        r_shift;
   logic               r_pd_sck;
   logic [23:0]        r_sample;
   logic [1:0]         r_sample_gain;
   logic               r_sample_valid;
   logic               r_timeout;
   logic               w_avg_clr;

   // Two-flop synchroniser; resets to "not ready" so no frame starts from reset.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_dout_m <= 1'b1;
         r_dout_s <= 1'b1;
      end else begin
         r_dout_m <= dout;
         r_dout_s <= r_dout_m;
      end
   end

   // Frame sequencer: ready wait with timeout, SCK generation, latch, power-down.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_WAIT_RDY;
         r_phase        <= '0;
         r_to_cnt       <= '0;
         r_bit_cnt      <= '0;
         r_target       <= 5'd25;
         r_gain         <= GAIN_A128;
         r_prev_gain    <= GAIN_A128;
         r_shift        <= '0;
         r_pd_sck       <= 1'b0;
         r_sample       <= '0;
         r_sample_gain  <= GAIN_A128;
         r_sample_valid <= 1'b0;
         r_timeout      <= 1'b0;
      end else begin
         r_sample_valid <= 1'b0;
         case (r_state)
            ST_WAIT_RDY: begin
               r_pd_sck <= 1'b0;
               if (!enable) begin
                  r_state  <= ST_PWRDN;
                  r_pd_sck <= 1'b1;
                  r_to_cnt <= '0;
               end else if (!r_dout_s) begin
                  r_state   <= ST_SCK_HI;
                  r_pd_sck  <= 1'b1;
                  r_gain    <= norm_gain(gain_sel);
                  r_target  <= pulses_for(gain_sel);
                  r_bit_cnt <= '0;
                  r_phase   <= '0;
                  r_shift   <= '0;
                  r_to_cnt  <= '0;
               end else if (r_to_cnt == TO_LAST) begin
                  r_timeout <= 1'b1;
                  r_to_cnt  <= '0;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end
            ST_SCK_HI: begin
               if (r_phase == PH_LAST) begin
                  r_phase  <= '0;
                  r_pd_sck <= 1'b0;
                  r_state  <= ST_SCK_LO;
                  // Only the first 24 pulses carry data; the rest select gain.
                  if (r_bit_cnt < 5'd24) begin
                     r_shift <= {r_shift[22:0], r_dout_s};
                  end
               end else begin
                  r_phase <= r_phase + PH_W'(1);
               end
            end
            ST_SCK_LO: begin
               if (r_phase == PH_LAST) begin
                  r_phase   <= '0;
                  r_bit_cnt <= r_bit_cnt + 5'd1;
                  if (r_bit_cnt + 5'd1 == r_target) begin
                     r_state <= ST_LATCH;
                  end else begin
                     r_state  <= ST_SCK_HI;
                     r_pd_sck <= 1'b1;
                  end
               end else begin
                  r_phase <= r_phase + PH_W'(1);
               end
            end
            ST_LATCH: begin
               // The gain pulses of a frame program the *next* conversion.
               r_sample       <= r_shift;
               r_sample_gain  <= r_prev_gain;
               r_prev_gain    <= r_gain;
               r_sample_valid <= 1'b1;
               r_timeout      <= 1'b0;
               if (!enable) begin
                  r_state  <= ST_PWRDN;
                  r_pd_sck <= 1'b1;
               end else begin
                  r_state <= ST_WAIT_RDY;
               end
            end
            ST_PWRDN: begin
               // The chip wakes up in A/128 regardless of earlier programming.
               r_prev_gain <= GAIN_A128;
               if (enable) begin
                  r_pd_sck <= 1'b0;
                  r_state  <= ST_WAIT_RDY;
               end else begin
                  r_pd_sck <= 1'b1;
               end
            end
            default: begin
               r_state  <= ST_WAIT_RDY;
               r_pd_sck <= 1'b0;
            end
         endcase
      end
   end

   // Power-down throws away any partially accumulated averaging block.
   assign w_avg_clr = (r_state == ST_PWRDN);

   hx711_avg #(
      .AVG_LOG2 (AVG_LOG2)
   ) u_avg (
      .clk_50      (clk_50),
      .rst_n       (rst_n),
      .i_clr       (w_avg_clr),
      .i_valid     (r_sample_valid),
      .i_sample    (r_sample),
      .o_avg       (avg),
      .o_avg_valid (avg_valid)
   );

   assign pd_sck       = r_pd_sck;
   assign sample       = r_sample;
   assign sample_gain  = r_sample_gain;
   assign sample_valid = r_sample_valid;
   assign timeout      = r_timeout;
   assign state_dbg    = r_state;

endmodule

// File: tb/tb_hx711_reader.sv
// Bench for hx711_reader: a behavioural HX711 drives DOUT from PD_SCK edges,
// and a reference model tracks gain tagging and block means.
module tb_hx711_reader;
   import hx711_pkg::*;

   localparam int SCK_HALF       = 4;
   localparam int TIMEOUT_CYCLES = 1000;
   localparam int AVG_LOG2       = 2;
   localparam int DEPTH          = 1 << AVG_LOG2;

   logic        clk_50   = 1'b0;
   logic        rst_n    = 1'b0;
   logic        dout     = 1'b1;
   logic        enable   = 1'b1;
   logic [1:0]  gain_sel = 2'b00;
   logic        pd_sck;
   logic [23:0] sample;
   logic [1:0]  sample_gain;
   logic        sample_valid;
   logic [23:0] avg;
   logic        avg_valid;
   logic        timeout;
   logic [2:0]  state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   // Monitor totals (written only by the monitor process).
   int   pulse_total = 0;
   int   bad_width   = 0;
   int   hi_len      = 0;
   int   sv_total    = 0;
   logic prev_sck    = 1'b0;

   // Reference model state.
   int model_prev_gain = 0;
   int blk_q[$];

   always #10 clk_50 = ~clk_50;

   hx711_reader #(
      .SCK_HALF       (SCK_HALF),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .AVG_LOG2       (AVG_LOG2)
   ) dut (
      .clk_50       (clk_50),
      .rst_n        (rst_n),
      .dout         (dout),
      .pd_sck       (pd_sck),
      .enable       (enable),
      .gain_sel     (gain_sel),
      .sample       (sample),
      .sample_gain  (sample_gain),
      .sample_valid (sample_valid),
      .avg          (avg),
      .avg_valid    (avg_valid),
      .timeout      (timeout),
      .state_dbg    (state_dbg)
   );

   // Count completed PD_SCK pulses and flag any whose high time is wrong.
   always @(negedge clk_50) begin
      if (prev_sck && !pd_sck) begin
         pulse_total++;
         if (hi_len != SCK_HALF) bad_width++;
         hi_len = 0;
      end
      if (pd_sck) hi_len++;
      if (sample_valid) sv_total++;
      prev_sck = pd_sck;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sext24(input logic [23:0] v);
      return {{8{v[23]}}, v};
   endfunction

   function automatic int floor_div(input int s, input int d);
      if (s >= 0) return s / d;
      return -((-s + d - 1) / d);
   endfunction

   // One conversion: the model HX711 presents `data`, the reader clocks it out.
   // drop_at: pulse number at which enable falls (0 = never).
   // abort_at: return with PD_SCK high after this pulse (0 = run to completion).
   task automatic do_frame(input logic [23:0] data, input logic [1:0] g,
                           input int drop_at, input int abort_at);
      int   n;
      int   k;
      int   cyc;
      int   p0;
      int   b0;
      int   sum;
      int   exp_avg;
      bit   exp_av;
      bit   seen;
      logic p;
      n = (g == 2'b01) ? 26 : (g == 2'b10) ? 27 : 25;
      gain_sel = g;
      repeat ($urandom_range(1, 6)) @(negedge clk_50);
      p0 = pulse_total;
      b0 = bad_width;
      dout = 1'b0;
      k = 0;
      cyc = 0;
      p = pd_sck;
      while (k < n && cyc < 2000) begin
         @(negedge clk_50);
         cyc++;
         if (pd_sck && !p) begin
            k++;
            dout = (k <= 24) ? data[24 - k] : 1'b1;
            if (k == drop_at) enable = 1'b0;
         end
         p = pd_sck;
         if (abort_at != 0 && k == abort_at) return;
      end
      check_eq("pulse_budget", k, n);
      seen = 1'b0;
      cyc = 0;
      while (!seen && cyc < 200) begin
         @(negedge clk_50);
         cyc++;
         if (sample_valid) seen = 1'b1;
      end
      check_eq("sample_valid_seen", seen, 1);
      if (seen) begin
         check_eq("sample", sample, data);
         check_eq("sample_gain", sample_gain, model_prev_gain);
         check_eq("timeout_clr", timeout, 0);
         check_eq("pulse_count", pulse_total - p0, n);
         check_eq("pulse_width", bad_width - b0, 0);
         check_eq("sck_after_latch", pd_sck, (drop_at != 0) ? 1 : 0);
         model_prev_gain = (g == 2'b11) ? 0 : int'(g);
         if (drop_at != 0) model_prev_gain = 0;
         blk_q.push_back(int'($signed(data)));
         exp_av = 1'b0;
         exp_avg = 0;
         if (blk_q.size() == DEPTH) begin
            sum = 0;
            foreach (blk_q[i]) sum += blk_q[i];
            exp_avg = floor_div(sum, DEPTH);
            exp_av = 1'b1;
            blk_q.delete();
         end else if (drop_at != 0) begin
            blk_q.delete();
         end
         @(negedge clk_50);
         check_eq("sample_valid_width", sample_valid, 0);
         check_eq("avg_valid", avg_valid, exp_av);
         if (exp_av) check_eq("avg", sext24(avg), exp_avg);
      end
   endtask

   initial begin
      int   cyc;
      int   sv0;
      bit   sck_seen;
      bit   held;
      logic [23:0] d;
      int   avg_vals[8];
      avg_vals = '{100, -4, 7, 1, -1, -1, -1, -2};

      // Reset values.
      repeat (3) @(negedge clk_50);
      check_eq("rst_pd_sck", pd_sck, 0);
      check_eq("rst_sample", sample, 0);
      check_eq("rst_sample_gain", sample_gain, 0);
      check_eq("rst_sample_valid", sample_valid, 0);
      check_eq("rst_avg", avg, 0);
      check_eq("rst_avg_valid", avg_valid, 0);
      check_eq("rst_timeout", timeout, 0);
      check_eq("rst_state", state_dbg, 3'(ST_WAIT_RDY));

      // Ready timeout with DOUT held high.
      @(negedge clk_50);
      rst_n = 1'b1;
      cyc = 0;
      sck_seen = 1'b0;
      while (!timeout && cyc < 1500) begin
         @(negedge clk_50);
         cyc++;
         if (pd_sck) sck_seen = 1'b1;
      end
      check_eq("timeout_cycle", cyc, TIMEOUT_CYCLES);
      check_eq("timeout_sck_low", sck_seen, 0);
      check_eq("timeout_sticky", timeout, 1);

      // Full-scale frames and gain tagging.
      do_frame(24'h7FFFFF, 2'b00, 0, 0);
      do_frame(24'h800000, 2'b10, 0, 0);
      check_eq("neg_full_scale", sext24(sample), 32'hFF800000);
      do_frame(24'($urandom), 2'b10, 0, 0);

      // Randomised frames and gains.
      for (int i = 0; i < 9; i++) begin
         do_frame(24'($urandom), 2'($urandom_range(0, 3)), 0, 0);
      end

      // Enable dropped mid-frame: frame completes, then power-down.
      do_frame(24'($urandom), 2'b01, 0, 0);
      do_frame(24'($urandom), 2'b01, 10, 0);
      held = 1'b1;
      repeat (20) begin
         @(negedge clk_50);
         if (!pd_sck) held = 1'b0;
      end
      check_eq("pwrdn_sck_held", held, 1);
      enable = 1'b1;
      cyc = 0;
      while (pd_sck && cyc < 10) begin
         @(negedge clk_50);
         cyc++;
      end
      check_eq("wake_sck_low", pd_sck, 0);
      do_frame(24'($urandom), 2'b10, 0, 0);

      // Reset asserted mid-SCK_HI.
      do_frame(24'($urandom), 2'b00, 0, 5);
      #3;
      check_eq("pre_rst_sck_high", pd_sck, 1);
      rst_n = 1'b0;
      #1;
      check_eq("arst_pd_sck", pd_sck, 0);
      check_eq("arst_sample", sample, 0);
      check_eq("arst_sample_gain", sample_gain, 0);
      check_eq("arst_avg", avg, 0);
      check_eq("arst_timeout", timeout, 0);
      check_eq("arst_state", state_dbg, 3'(ST_WAIT_RDY));
      dout = 1'b1;
      repeat (3) @(negedge clk_50);
      rst_n = 1'b1;
      model_prev_gain = 0;
      blk_q.delete();
      sv0 = sv_total;
      repeat (100) @(negedge clk_50);
      check_eq("no_sample_after_rst", sv_total - sv0, 0);

      // Directed block means: 100,-4,7,1 -> 26 and -1,-1,-1,-2 -> -2.
      for (int i = 0; i < 8; i++) begin
         d = 24'(avg_vals[i]);
         do_frame(d, 2'($urandom_range(0, 3)), 0, 0);
         if (i == 3) check_eq("avg_block_a", sext24(avg), 32'd26);
         if (i == 7) check_eq("avg_block_b", sext24(avg), 32'hFFFFFFFE);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global guard so a stuck run still reports.
   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
